// File: rtl/fault_vector_sequencer.sv
// fault_vector_sequencer: steps a 3-bit vector through all 8 patterns, sampling fault after SETTLE cycles each.
// Optional macro FVS_STOP_ON_FAULT_EN ends the run at the first detected fault.
module fault_vector_sequencer #(
  parameter int SETTLE = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic       fault,
  output logic       A,
  output logic       B,
  output logic       C,
  output logic       busy,
  output logic       done,
  output logic [7:0] detect_mask,
  output logic [3:0] fault_count,
  output logic       any_fault
);
  typedef enum logic [1:0] {IDLE, APPLY, SAMPLE, DONE} state_e;
  localparam logic [7:0] RELOAD = 8'(SETTLE - 1);
  state_e     state_q, state_d;
  logic [2:0] vec_q, vec_d, abc_q;
  logic [7:0] cnt_q, cnt_d, mask_q, mask_d;
  logic [3:0] count_q;
  logic       busy_q, done_q, any_q, stop;
`ifdef FVS_STOP_ON_FAULT_EN
  assign stop = fault;
`else
  assign stop = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    mask_d  = mask_q;
    case (state_q)
      APPLY: begin
        state_d = abort ? IDLE : (cnt_q == 8'd0 ? SAMPLE : APPLY);
        cnt_d   = (abort || cnt_q == 8'd0) ? cnt_q : cnt_q - 8'd1;
      end
      SAMPLE: begin
        mask_d[vec_q] = fault;
        if (abort) state_d = IDLE;
        else if (vec_q == 3'd7 || stop) state_d = DONE;
        else begin
          vec_d   = vec_q + 3'd1;
          cnt_d   = RELOAD;
          state_d = APPLY;
        end
      end
      default: begin
        // abort takes priority over a simultaneous start
        if (start && !abort) begin
          mask_d  = 8'h00;
          vec_d   = 3'd0;
          cnt_d   = RELOAD;
          state_d = APPLY;
        end else state_d = IDLE;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      vec_q   <= 3'd0;
      cnt_q   <= 8'd0;
      mask_q  <= 8'h00;
      count_q <= 4'd0;
      any_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      abc_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      mask_q  <= mask_d;
      count_q <= 4'($countones(mask_q));
      any_q   <= |mask_q;
      busy_q  <= state_d == APPLY || state_d == SAMPLE;
      done_q  <= state_d == DONE;
      abc_q   <= (state_d == APPLY || state_d == SAMPLE) ? vec_d : 3'd0;
    end
  end
  assign {A, B, C}   = abc_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign detect_mask = mask_q;
  assign fault_count = count_q;
  assign any_fault   = any_q;
endmodule

// File: tb/tb_fault_vector_sequencer.sv
// tb_fault_vector_sequencer: random runs against a timing/mask model, scoreboard checked at each run end.
module tb_fault_vector_sequencer;
  localparam int S = 4;
  localparam int P = S + 1;
  localparam int NAT = 8 * P;
  localparam int NONE = 1000;
  logic clk = 1'b0, rst, start, abort, fault;
  logic A, B, C, busy, done, any_fault;
  logic [7:0] detect_mask;
  logic [3:0] fault_count;
  typedef struct {logic [7:0] mask; bit dn; int end_cyc;} item_t;
  item_t q[$];
  int total = 0, bad = 0, cyc = 0;
  int t0 = -NONE, last_d = 0;
  bit mon_en = 0, pbusy = 0, cnt_pend = 0;
  int cnt_exp, any_exp, md;
  item_t it;
  fault_vector_sequencer #(.SETTLE(S)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .fault(fault),
    .A(A), .B(B), .C(C), .busy(busy), .done(done),
    .detect_mask(detect_mask), .fault_count(fault_count), .any_fault(any_fault)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d expected=%0d cycle=%0d", name, act, exp, cyc);
    end
  endtask
  always @(negedge clk) if (mon_en) begin
    md = cyc - t0;
    chk("busy", busy, (md >= 1 && md <= last_d) ? 1 : 0);
    chk("abc", {A, B, C}, (md >= 1 && md <= last_d) ? (md - 1) / P : 0);
    if (cnt_pend) begin
      chk("fault_count", fault_count, cnt_exp);
      chk("any_fault", any_fault, any_exp);
      cnt_pend = 0;
    end
    if (pbusy && !busy) begin
      if (q.size() == 0) chk("unexpected_run_end", 1, 0);
      else begin
        it = q.pop_front();
        chk("done", done, it.dn);
        chk("end_cycle", cyc, it.end_cyc);
        chk("detect_mask", detect_mask, it.mask);
        cnt_exp = $countones(it.mask);
        any_exp = it.mask != 0;
        cnt_pend = 1;
      end
    end else chk("done_low", done, 0);
    pbusy = busy;
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic idle(input int n);
    start = 0; abort = 0; rst = 0;
    for (int i = 0; i < n; i++) begin
      fault = 1'($urandom);
      step();
    end
  endtask
  task automatic run(input logic [7:0] tbl, input int ab_off, input int rs_off, input int re_off);
    int nat, cut, lim, stop_d;
    item_t x;
    nat = NAT;
`ifdef FVS_STOP_ON_FAULT_EN
    for (int k = 7; k >= 0; k--) if (tbl[k]) nat = (k + 1) * P;
`endif
    cut = nat < ab_off ? nat : ab_off;
    cut = cut < rs_off ? cut : rs_off;
    lim = nat < ab_off ? nat : ab_off;
    x.mask = 8'h00;
    for (int k = 0; k < 8; k++) if (tbl[k] && (k + 1) * P <= lim) x.mask[k] = 1'b1;
    if (rs_off <= nat) x.mask = 8'h00;
    x.dn = ab_off > nat && rs_off > nat;
    x.end_cyc = cyc + cut + 1;
    q.push_back(x);
    t0 = cyc;
    last_d = cut;
    stop_d = x.dn ? nat : cut;
    for (int d = 0; d <= stop_d; d++) begin
      start = d == 0 || d == re_off;
      abort = d == ab_off;
      rst = d == rs_off;
      fault = (d >= P && d <= cut && d % P == 0) ? tbl[d / P - 1] : 1'($urandom);
      step();
    end
    start = 0; abort = 0; rst = 0;
  endtask
  initial begin
    rst = 1; start = 0; abort = 0; fault = 0;
    repeat (3) step();
    chk("reset_mask", detect_mask, 0);
    chk("reset_count", fault_count, 0);
    chk("reset_any", any_fault, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_abc", {A, B, C}, 0);
    rst = 0;
    mon_en = 1;
    idle(2);
    run(8'h00, NONE, NONE, NONE); idle(3);
    run(8'h69, NONE, NONE, NONE); idle(3);
    run(8'h6b, 12, NONE, NONE); idle(3);
    run(8'h00, NONE, NONE, 20); idle(3);
    run(8'hff, NONE, 25, NONE); idle(3);
    run(8'h69, NONE, NONE, NONE);
    run(8'h80, NATjoin(), NONE, NONE); idle(3);
    for (int r = 0; r < 14; r++) begin
      int sel, ab, rs, re;
      sel = $urandom_range(0, 9);
      ab = sel < 3 ? $urandom_range(1, NAT) : NONE;
      rs = sel == 3 ? $urandom_range(1, NAT) : NONE;
      re = sel > 6 ? $urandom_range(1, 8) : NONE;
      run(8'($urandom), ab, rs, re);
      idle($urandom_range(0, 2));
    end
    idle(3);
    chk("scoreboard_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  function automatic int NATjoin();
    return NAT;
  endfunction
endmodule
